// File: rtl/kbd_text_buffer.sv
// Keyboard-to-text-grid buffer: turns scanner keypresses into a ROWS x COLS character RAM
// with cursor, backspace, newline and clear-screen handling, plus a registered display read port.
module kbd_text_buffer #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_byte,
    input  logic             kbd_ready,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic [7:0]       rd_char,
    output logic [COL_W-1:0] cursor_col,
    output logic [ROW_W-1:0] cursor_row,
    output logic             busy,
    output logic             overflow
);
    localparam int                CELLS     = ROWS * COLS;
    localparam int                ADDR_W    = COL_W + ROW_W;
    localparam logic [7:0]        BLANK     = 8'h20;
    localparam logic [7:0]        KEY_BS    = 8'h08;
    localparam logic [7:0]        KEY_ENTER = 8'h0D;
    localparam logic [7:0]        KEY_ESC   = 8'h1B;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLR_ROW, CLR_ALL} state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    logic [7:0]        mem [CELLS];

    logic [1:0]        sync_reg;
    logic              ready_prev_reg;
    logic              key_edge;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              pend_valid_reg;
    logic [7:0]        pend_byte_reg;
    logic [7:0]        cmd_reg;
    logic [COL_W-1:0]  cursor_col_reg;
    logic [ROW_W-1:0]  cursor_row_reg;
    logic              overflow_reg;
    logic [7:0]        rd_char_reg;

    logic              is_print;
    logic [ROW_W-1:0]  row_inc;
    logic [ADDR_W-1:0] row_base;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_in_range;
    logic [ADDR_W-1:0] rd_addr;

    // kbd_ready is asynchronous to clk: two-flop synchroniser, then rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b00;
            ready_prev_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], kbd_ready};
            ready_prev_reg <= sync_reg[1];
        end
    end

    assign key_edge = sync_reg[1] & ~ready_prev_reg;

    assign is_print = (cmd_reg >= 8'h20) && (cmd_reg <= 8'h7E);
    assign row_inc  = (cursor_row_reg == LAST_ROW) ? '0 : cursor_row_reg + ROW_W'(1);
    assign row_base = cell_addr(cursor_row_reg, '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= CLR_ALL;
            clr_ptr_reg    <= '0;
            pend_valid_reg <= 1'b0;
            pend_byte_reg  <= 8'h00;
            cmd_reg        <= 8'h00;
            cursor_col_reg <= '0;
            cursor_row_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_valid_reg) begin
                        cmd_reg        <= pend_byte_reg;
                        pend_valid_reg <= 1'b0;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    state_reg <= IDLE;
                    if (is_print) begin
                        if (cursor_col_reg == LAST_COL) begin
                            cursor_col_reg <= '0;
                            cursor_row_reg <= row_inc;
                            clr_ptr_reg    <= '0;
                            state_reg      <= CLR_ROW;
                        end else begin
                            cursor_col_reg <= cursor_col_reg + COL_W'(1);
                        end
                    end else if (cmd_reg == KEY_ENTER) begin
                        cursor_col_reg <= '0;
                        cursor_row_reg <= row_inc;
                        clr_ptr_reg    <= '0;
                        state_reg      <= CLR_ROW;
                    end else if (cmd_reg == KEY_BS) begin
                        // Backspace stops at column 0; it never pulls the cursor up a row.
                        if (cursor_col_reg != '0) begin
                            cursor_col_reg <= cursor_col_reg - COL_W'(1);
                        end
                    end else if (cmd_reg == KEY_ESC) begin
                        cursor_col_reg <= '0;
                        cursor_row_reg <= '0;
                        clr_ptr_reg    <= '0;
                        state_reg      <= CLR_ALL;
                    end
                end
                CLR_ROW: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                    if (clr_ptr_reg == ROW_LAST) begin
                        state_reg <= IDLE;
                    end
                end
                CLR_ALL: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                    if (clr_ptr_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // One-entry holding slot; a keypress arriving while it is full is lost.
            if (key_edge) begin
                if (pend_valid_reg) begin
                    overflow_reg <= 1'b1;
                end else begin
                    pend_valid_reg <= 1'b1;
                    pend_byte_reg  <= kbd_byte;
                end
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = BLANK;
        case (state_reg)
            EXEC: begin
                if (is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(cursor_row_reg, cursor_col_reg);
                    wr_data = cmd_reg;
                end else if (cmd_reg == KEY_BS && cursor_col_reg != '0) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(cursor_row_reg, cursor_col_reg - COL_W'(1));
                end
            end
            CLR_ROW: begin
                wr_en   = 1'b1;
                wr_addr = row_base + clr_ptr_reg;
            end
            CLR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr_reg;
            end
            default: ;
        endcase
    end

    // Out-of-range coordinates must not alias onto a neighbouring row.
    assign rd_in_range = (rd_col <= LAST_COL) && (rd_row <= LAST_ROW);
    assign rd_addr     = rd_in_range ? cell_addr(rd_row, rd_col) : '0;

    // Read-before-write: a same-cycle read of the cell being written returns the old byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rst) begin
            rd_char_reg <= BLANK;
        end else if (rd_in_range) begin
            rd_char_reg <= mem[rd_addr];
        end else begin
            rd_char_reg <= BLANK;
        end
    end

    assign rd_char    = rd_char_reg;
    assign cursor_col = cursor_col_reg;
    assign cursor_row = cursor_row_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg == CLR_ROW) || (state_reg == CLR_ALL);

endmodule

// File: tb/tb_kbd_text_buffer.sv
// Bench for kbd_text_buffer: keystrokes are applied to a screen-array model; display reads
// push the model's expected character into a queue that a monitor drains against rd_char.
module tb_kbd_text_buffer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_byte = 8'h00;
    logic       kbd_ready = 1'b0;
    logic [6:0] rd_col = '0;
    logic [4:0] rd_row = '0;
    logic [7:0] rd_char;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;
    logic       overflow;

    kbd_text_buffer #(.COLS(COLS), .ROWS(ROWS), .COL_W(7), .ROW_W(5)) dut (
        .clk(clk), .rst(rst), .kbd_byte(kbd_byte), .kbd_ready(kbd_ready),
        .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the visible screen and cursor.
    logic [7:0] scr [ROWS][COLS];
    int         cur_r;
    int         cur_c;

    // Scoreboard for the read port.
    logic [7:0] exp_q [$];
    int         tag_q [$];
    logic       rd_req = 1'b0;
    logic       rd_req_d = 1'b0;
    logic [7:0] mon_exp;
    int         mon_tag;

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: read returned %h with nothing expected", rd_char);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (rd_char !== mon_exp)begin
                    errors++;
                    $display("FAIL rd_char row=%0d col=%0d: got %h, required %h",
                             mon_tag / 1000, mon_tag % 1000, rd_char, mon_exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic model_new_row();
        cur_c = 0;
        cur_r = (cur_r + 1) % ROWS;
        for (int c = 0; c < COLS; c++) scr[cur_r][c] = 8'h20;
    endtask

    task automatic model_key(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[cur_r][cur_c] = b;
            if (cur_c == COLS - 1) model_new_row();
            else cur_c++;
        end else if (b == 8'h0D) begin
            model_new_row();
        end else if (b == 8'h08) begin
            if (cur_c > 0) begin
                cur_c--;
                scr[cur_r][cur_c] = 8'h20;
            end
        end else if (b == 8'h1B) begin
            model_clear_all();
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        kbd_byte  = b;
        kbd_ready = 1'b1;
        repeat (4) @(negedge clk);
        kbd_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy !== 1'b0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic press_key(input logic [7:0] b);
        model_key(b);
        pulse(b);
        wait_idle();
        $display("key %h -> cursor (%0d,%0d) expected (%0d,%0d)", b, cursor_row, cursor_col, cur_r, cur_c);
    endtask

    task automatic check_cursor(input string nm);
        check({nm, "_row"}, cursor_row, cur_r);
        check({nm, "_col"}, cursor_col, cur_c);
    endtask

    task automatic issue_read(input int r, input int c, input logic [7:0] e);
        rd_row = r[4:0];
        rd_col = c[6:0];
        exp_q.push_back(e);
        tag_q.push_back(r * 1000 + c);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_row(input int r);
        for (int c = 0; c < COLS; c++) issue_read(r, c, scr[r][c]);
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++) read_row(r);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Reset pulse of one clock, then the reset-state and full-clear checks.
    task automatic do_reset(input string nm);
        int nb;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear_all();
        check({nm, "_busy"}, busy, 1);
        check({nm, "_overflow"}, overflow, 0);
        check({nm, "_rd_char"}, rd_char, 8'h20);
        check_cursor(nm);
        count_busy(nb);
        check({nm, "_busy_cycles"}, nb, 2400);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(33, 126));
    endfunction

    initial begin
        int lat;
        int nb;
        int n;
        int sel;
        logic [7:0] b;

        // Power-up reset and clear, then preload some non-blank content.
        do_reset("init");
        for (int i = 0; i < 10; i++) press_key(rand_print());
        check_cursor("preload");
        for (int c = 0; c < 12; c++) issue_read(0, c, scr[0][c]);

        // Reset must wipe the preloaded content.
        do_reset("reset");
        read_all();
        check_cursor("after_clear");

        // "AB": first write visible on rd_char 6 negedges after kbd_ready rises.
        rd_row = '0;
        rd_col = '0;
        kbd_byte  = 8'h41;
        kbd_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 4) kbd_ready = 1'b0;
            if (lat == 0 && rd_char === 8'h41) lat = k;
        end
        check("ab_first_write_latency", lat, 6);
        model_key(8'h41);
        wait_idle();
        repeat (6) @(negedge clk);
        press_key(8'h42);
        check_cursor("ab");
        issue_read(0, 0, scr[0][0]);
        issue_read(0, 1, scr[0][1]);
        issue_read(0, 2, scr[0][2]);

        // Fill rows 0 and 1, then 29 Enters wrap from row 29 back to a cleared row 0.
        press_key(8'h1B);
        for (int i = 0; i < 3; i++) press_key(rand_print());
        press_key(8'h0D);
        for (int i = 0; i < 5; i++) press_key(rand_print());
        for (int i = 0; i < 29; i++) begin
            if (i == 28) check("row_before_wrap", cursor_row, 29);
            press_key(8'h0D);
        end
        check_cursor("enter_wrap");
        read_row(0);
        issue_read(1, 0, scr[1][0]);

        // Line wrap: 80 'a' keys, the last one clears row 1 for exactly 80 cycles.
        for (int i = 0; i < 79; i++) press_key(8'h61);
        model_key(8'h61);
        kbd_byte  = 8'h61;
        kbd_ready = 1'b1;
        repeat (3) @(negedge clk);
        kbd_ready = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        count_busy(nb);
        check("wrap_busy_cycles", nb, 80);
        repeat (4) @(negedge clk);
        check_cursor("wrap");
        read_row(0);
        read_row(1);

        // Out-of-range reads must be blank even where the flat address would alias (1,0).
        press_key(8'h62);
        issue_read(0, 80, 8'h20);
        issue_read(0, 127, 8'h20);
        issue_read(30, 0, 8'h20);
        issue_read(31, 5, 8'h20);
        issue_read(1, 0, scr[1][0]);

        // Backspace and Enter.
        press_key(8'h1B);
        press_key(8'h41);
        press_key(8'h08);
        issue_read(0, 0, scr[0][0]);
        check_cursor("bs1");
        press_key(8'h08);
        check_cursor("bs2");
        press_key(8'h0D);
        check_cursor("bs_enter");
        press_key(8'h08);
        check_cursor("bs_row_start");

        // Randomised keystrokes against the model.
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70) b = 8'($urandom_range(32, 126));
            else if (sel < 80) b = 8'h08;
            else if (sel < 88) b = 8'h0D;
            else if (sel < 98) begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h08 || b == 8'h0D || b == 8'h1B) b = 8'($urandom_range(127, 255));
            end else b = 8'h1B;
            press_key(b);
            check_cursor("rand");
        end
        read_all();
        check("rand_overflow", overflow, 0);

        // Overflow: two keys during a full clear; only the first survives.
        model_key(8'h1B);
        model_key(8'h58);
        pulse(8'h1B);
        pulse(8'h58);
        pulse(8'h59);
        check("ovf_busy_during_keys", busy, 1);
        wait_idle();
        check("ovf_flag", overflow, 1);
        check_cursor("ovf");
        issue_read(0, 0, scr[0][0]);
        issue_read(0, 1, scr[0][1]);

        // Reset ~1000 cycles into a clear, with a key waiting in the pending slot.
        pulse(8'h1B);
        pulse(8'h51);
        repeat (988) @(negedge clk);
        check("midclr_busy_before", busy, 1);
        check("midclr_ovf_before", overflow, 1);
        do_reset("midclr");
        repeat (10) @(negedge clk);
        check_cursor("midclr_no_pending");
        issue_read(0, 0, scr[0][0]);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
